// File: rtl/raw_stream_pkg.sv
`default_nettype none
//------------------------------------------------------------------
// raw_stream_pkg: shared state type and widths for raw_stream_gen.
// Rev 1.0
//------------------------------------------------------------------
package raw_stream_pkg;
  localparam int PIX_W       = 12;
  localparam int CNT_W       = 11;
  localparam int FRAME_CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LINE   = 2'd1,
    HBLANK = 2'd2,
    VBLANK = 2'd3
  } state_t;
endpackage
`default_nettype wire

// File: rtl/raw_stream_timing.sv
`default_nettype none
//------------------------------------------------------------------
// raw_stream_timing: free-running raster FSM with x/y/blank counters.
// Rev 1.0
//------------------------------------------------------------------
module raw_stream_timing
  import raw_stream_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 16,
  parameter int V_BLANK  = 4
)(
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iSTART,
  output state_t           oState,
  output logic [CNT_W-1:0] oX,
  output logic [CNT_W-1:0] oY,
  output logic             oFrameDone
);

  localparam int c_vbCycles = V_BLANK * (H_ACTIVE + H_BLANK);
  localparam int c_blkW     = $clog2(c_vbCycles + 1);

  localparam logic [CNT_W-1:0]  c_xLast  = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0]  c_yLast  = CNT_W'(V_ACTIVE - 1);
  localparam logic [c_blkW-1:0] c_hbLast = c_blkW'(H_BLANK - 1);
  localparam logic [c_blkW-1:0] c_vbLast = c_blkW'(c_vbCycles - 1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_x;
  logic [CNT_W-1:0]    r_y;
  logic [c_blkW-1:0]   r_blank;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_blank <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (iSTART) begin
            r_state <= LINE;
            r_x     <= '0;
            r_y     <= '0;
          end
        end
        LINE: begin
          if (r_x == c_xLast) begin
            r_x     <= '0;
            r_blank <= '0;
            r_state <= HBLANK;
          end else begin
            r_x <= r_x + CNT_W'(1);
          end
        end
        HBLANK: begin
          if (r_blank == c_hbLast) begin
            r_blank <= '0;
            if (r_y == c_yLast) begin
              r_y     <= '0;
              r_state <= VBLANK;
            end else begin
              r_y     <= r_y + CNT_W'(1);
              r_state <= LINE;
            end
          end else begin
            r_blank <= r_blank + c_blkW'(1);
          end
        end
        VBLANK: begin
          // iSTART is only looked at here and in IDLE, so a frame always finishes.
          if (r_blank == c_vbLast) begin
            r_blank <= '0;
            r_state <= iSTART ? LINE : IDLE;
          end else begin
            r_blank <= r_blank + c_blkW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign oState     = r_state;
  assign oX         = r_x;
  assign oY         = r_y;
  assign oFrameDone = (r_state == VBLANK) && (r_blank == c_vbLast);

endmodule
`default_nettype wire

// File: rtl/raw_stream_gen.sv
`default_nettype none
//------------------------------------------------------------------
// raw_stream_gen: raster raw-pixel transmitter fed from a show-ahead FIFO.
// Optional test-pattern source enabled by macro RAW_TEST_PATTERN_EN.  Rev 1.0
//------------------------------------------------------------------
module raw_stream_gen
  import raw_stream_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 16,
  parameter int V_BLANK  = 4
)(
  input  logic                   iCLK,
  input  logic                   iRST,
  input  logic                   iSTART,
  input  logic [PIX_W-1:0]       iDATA,
  input  logic                   iEMPTY,
`ifdef RAW_TEST_PATTERN_EN
  input  logic                   iPATTERN_SEL,
`endif
  output logic                   oRDREQ,
  output logic [CNT_W-1:0]       oX_Cont,
  output logic [CNT_W-1:0]       oY_Cont,
  output logic [PIX_W-1:0]       oDATA,
  output logic                   oDVAL,
  output logic                   oLVAL,
  output logic                   oFVAL,
  output logic [FRAME_CNT_W-1:0] oFrame_Cont,
  output logic                   oUNDERFLOW
);

  state_t           w_state;
  logic [CNT_W-1:0] w_x;
  logic [CNT_W-1:0] w_y;
  logic             w_frameDone;
  logic             w_line;
  logic             w_start;
  logic             w_patSel;
  logic [PIX_W-1:0] w_pix;

  raw_stream_timing #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .H_BLANK  (H_BLANK),
    .V_BLANK  (V_BLANK)
  ) u_timing (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iSTART     (iSTART),
    .oState     (w_state),
    .oX         (w_x),
    .oY         (w_y),
    .oFrameDone (w_frameDone)
  );

  assign w_line  = (w_state == LINE);
  assign w_start = (w_state == IDLE) && iSTART;

`ifdef RAW_TEST_PATTERN_EN
  logic r_patSel;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST)        r_patSel <= 1'b0;
    else if (w_start) r_patSel <= iPATTERN_SEL;
  end

  assign w_patSel = r_patSel;
  assign w_pix    = r_patSel ? {w_y[5:0], w_x[5:0]} : (iEMPTY ? '0 : iDATA);
`else
  assign w_patSel = 1'b0;
  assign w_pix    = iEMPTY ? '0 : iDATA;
`endif

  assign oRDREQ = w_line && !iEMPTY && !w_patSel;
  assign oLVAL  = oDVAL;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oX_Cont     <= '0;
      oY_Cont     <= '0;
      oDATA       <= '0;
      oDVAL       <= 1'b0;
      oFVAL       <= 1'b0;
      oFrame_Cont <= '0;
      oUNDERFLOW  <= 1'b0;
    end else begin
      oDVAL <= w_line;
      // Blanking between lines stays inside the frame; only VBLANK/IDLE drop it.
      oFVAL <= w_line || (w_state == HBLANK);
      if (w_line) begin
        oX_Cont <= w_x;
        oY_Cont <= w_y;
        oDATA   <= w_pix;
      end
      if (w_frameDone)
        oFrame_Cont <= oFrame_Cont + FRAME_CNT_W'(1);
      if (w_start)
        oUNDERFLOW <= 1'b0;
      else if (w_line && iEMPTY && !w_patSel)
        oUNDERFLOW <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_raw_stream_gen.sv
`default_nettype none
//------------------------------------------------------------------
// tb_raw_stream_gen: directed vector bench for raw_stream_gen (4x2 frame).
// Rev 1.0
//------------------------------------------------------------------
module tb_raw_stream_gen;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iSTART;
  logic [11:0] iDATA;
  logic        iEMPTY;
`ifdef RAW_TEST_PATTERN_EN
  logic        iPATTERN_SEL = 1'b0;
`endif
  logic        oRDREQ;
  logic [10:0] oX_Cont;
  logic [10:0] oY_Cont;
  logic [11:0] oDATA;
  logic        oDVAL;
  logic        oLVAL;
  logic        oFVAL;
  logic [31:0] oFrame_Cont;
  logic        oUNDERFLOW;

  raw_stream_gen #(
    .H_ACTIVE (4),
    .V_ACTIVE (2),
    .H_BLANK  (2),
    .V_BLANK  (1)
  ) dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .iSTART      (iSTART),
    .iDATA       (iDATA),
    .iEMPTY      (iEMPTY),
`ifdef RAW_TEST_PATTERN_EN
    .iPATTERN_SEL(iPATTERN_SEL),
`endif
    .oRDREQ      (oRDREQ),
    .oX_Cont     (oX_Cont),
    .oY_Cont     (oY_Cont),
    .oDATA       (oDATA),
    .oDVAL       (oDVAL),
    .oLVAL       (oLVAL),
    .oFVAL       (oFVAL),
    .oFrame_Cont (oFrame_Cont),
    .oUNDERFLOW  (oUNDERFLOW)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic        st;
    logic        emp;
    logic        rdq;
    logic        dval;
    logic        fval;
    logic [10:0] x;
    logic [10:0] y;
    logic [11:0] data;
    logic        uf;
    logic [31:0] frm;
  } vec_t;

  vec_t        tbl[$];
  int          nTests = 0;
  int          nFail  = 0;
  logic [11:0] mem[16];
  int          ptr = 0;
  int          cnt = 0;
  logic        fifoInf = 1'b0;
  logic        forceEmpty = 1'b0;
  logic        pop = 1'b0;
  int          riseCyc[8];
  logic [31:0] riseFrm[8];
  int          nRise = 0;
  logic        prevF = 1'b0;
  int          nPop = 0;
  int          nUf = 0;
  int          nHit = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic add(input int n, input logic st, input logic emp, input logic rdq,
                     input logic dval, input logic fval, input int x, input int y,
                     input int data, input logic uf, input int frm);
    vec_t v;
    v.st = st; v.emp = emp; v.rdq = rdq; v.dval = dval; v.fval = fval;
    v.x = 11'(x); v.y = 11'(y); v.data = 12'(data); v.uf = uf; v.frm = 32'(frm);
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  // Show-ahead FIFO model: head word presented whenever not empty.
  task automatic drive();
    iEMPTY = forceEmpty || (!fifoInf && ptr >= cnt);
    iDATA  = fifoInf ? 12'h5A5 : ((ptr < cnt) ? mem[ptr] : 12'h000);
  endtask

  task automatic tick(input logic st, input logic emp);
    @(negedge iCLK);
    iSTART = st;
    forceEmpty = emp;
    drive();
    #1;
    pop = oRDREQ;
    @(posedge iCLK);
    #1;
    if (pop) ptr++;
    drive();
  endtask

  initial begin
    // Reset with arbitrary inputs
    iRST = 1'b0; iSTART = 1'b1; iEMPTY = 1'b0; iDATA = 12'hABC;
    repeat (3) @(posedge iCLK);
    #1;
    chk("rst_dval",  oDVAL, 0);
    chk("rst_lval",  oLVAL, 0);
    chk("rst_fval",  oFVAL, 0);
    chk("rst_x",     oX_Cont, 0);
    chk("rst_y",     oY_Cont, 0);
    chk("rst_data",  oDATA, 0);
    chk("rst_frame", oFrame_Cont, 0);
    chk("rst_uf",    oUNDERFLOW, 0);
    chk("rst_rdreq", oRDREQ, 0);

    for (int i = 0; i < 16; i++) mem[i] = 12'(12'h101 + i);
    cnt = 16; ptr = 0; fifoInf = 1'b0; forceEmpty = 1'b0; iSTART = 1'b0;
    drive();
    @(negedge iCLK); iRST = 1'b1;

    // Frame A: clean 4x2 frame, then back to IDLE
    add(1, 1,0,0, 0,0, 0,0, 'h000, 0,0);
    add(1, 0,0,1, 1,1, 0,0, 'h101, 0,0);
    add(1, 0,0,1, 1,1, 1,0, 'h102, 0,0);
    add(1, 0,0,1, 1,1, 2,0, 'h103, 0,0);
    add(1, 0,0,1, 1,1, 3,0, 'h104, 0,0);
    add(2, 0,0,0, 0,1, 3,0, 'h104, 0,0);
    add(1, 0,0,1, 1,1, 0,1, 'h105, 0,0);
    add(1, 0,0,1, 1,1, 1,1, 'h106, 0,0);
    add(1, 0,0,1, 1,1, 2,1, 'h107, 0,0);
    add(1, 0,0,1, 1,1, 3,1, 'h108, 0,0);
    add(2, 0,0,0, 0,1, 3,1, 'h108, 0,0);
    add(5, 0,0,0, 0,0, 3,1, 'h108, 0,0);
    add(1, 0,0,0, 0,0, 3,1, 'h108, 0,1);
    // Frame B: FIFO empty on the x=2 cycle of line 0
    add(1, 1,0,0, 0,0, 3,1, 'h108, 0,1);
    add(1, 0,0,1, 1,1, 0,0, 'h109, 0,1);
    add(1, 0,0,1, 1,1, 1,0, 'h10A, 0,1);
    add(1, 0,1,0, 1,1, 2,0, 'h000, 1,1);
    add(1, 0,0,1, 1,1, 3,0, 'h10B, 1,1);
    add(2, 0,0,0, 0,1, 3,0, 'h10B, 1,1);
    add(1, 0,0,1, 1,1, 0,1, 'h10C, 1,1);
    add(1, 0,0,1, 1,1, 1,1, 'h10D, 1,1);
    add(1, 0,0,1, 1,1, 2,1, 'h10E, 1,1);
    add(1, 0,0,1, 1,1, 3,1, 'h10F, 1,1);
    add(2, 0,0,0, 0,1, 3,1, 'h10F, 1,1);
    add(5, 0,0,0, 0,0, 3,1, 'h10F, 1,1);
    add(1, 0,0,0, 0,0, 3,1, 'h10F, 1,2);
    // Frame C start clears the sticky underflow
    add(1, 1,0,0, 0,0, 3,1, 'h10F, 0,2);
    add(1, 0,0,1, 1,1, 0,0, 'h110, 0,2);

    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].st, tbl[i].emp);
      chk($sformatf("v%0d_rdreq", i), pop,  tbl[i].rdq);
      chk($sformatf("v%0d_dval", i), oDVAL, tbl[i].dval);
      chk($sformatf("v%0d_lval", i), oLVAL, tbl[i].dval);
      chk($sformatf("v%0d_fval", i), oFVAL, tbl[i].fval);
      chk($sformatf("v%0d_x", i),    oX_Cont, tbl[i].x);
      chk($sformatf("v%0d_y", i),    oY_Cont, tbl[i].y);
      if (tbl[i].dval) chk($sformatf("v%0d_data", i), oDATA, tbl[i].data);
      chk($sformatf("v%0d_uf", i),   oUNDERFLOW, tbl[i].uf);
      chk($sformatf("v%0d_frame", i), oFrame_Cont, tbl[i].frm);
    end

    // Continuous mode: 18-cycle frame period
    @(negedge iCLK); iRST = 1'b0; iSTART = 1'b0; fifoInf = 1'b1; forceEmpty = 1'b0; drive();
    @(negedge iCLK); iRST = 1'b1;
    prevF = 1'b0; nRise = 0;
    for (int c = 0; c < 100; c++) begin
      tick(1'b1, 1'b0);
      if (oFVAL && !prevF && nRise < 8) begin
        riseCyc[nRise] = c;
        riseFrm[nRise] = oFrame_Cont;
        nRise++;
      end
      prevF = oFVAL;
    end
    chk("cont_rise_count", (nRise >= 4) ? 1 : 0, 1);
    chk("cont_first_frame", riseFrm[0], 0);
    for (int k = 1; k < 4; k++) begin
      chk($sformatf("cont_period%0d", k), riseCyc[k] - riseCyc[k-1], 18);
      chk($sformatf("cont_frame_inc%0d", k), riseFrm[k] - riseFrm[k-1], 1);
    end

    // Reset mid-line at x=2 of line 1
    @(negedge iCLK); iRST = 1'b0; iSTART = 1'b0;
    @(negedge iCLK); iRST = 1'b1;
    tick(1'b1, 1'b0);
    for (int c = 0; c < 8; c++) tick(1'b0, 1'b0);
    chk("mid_pre_x", oX_Cont, 1);
    chk("mid_pre_y", oY_Cont, 1);
    @(negedge iCLK); iRST = 1'b0;
    #1;
    chk("mid_rst_dval",  oDVAL, 0);
    chk("mid_rst_fval",  oFVAL, 0);
    chk("mid_rst_x",     oX_Cont, 0);
    chk("mid_rst_y",     oY_Cont, 0);
    chk("mid_rst_data",  oDATA, 0);
    chk("mid_rst_rdreq", oRDREQ, 0);
    @(negedge iCLK); iRST = 1'b1; iSTART = 1'b1;
    @(posedge iCLK); #1;
    tick(1'b0, 1'b0);
    chk("restart_dval", oDVAL, 1);
    chk("restart_x",    oX_Cont, 0);
    chk("restart_y",    oY_Cont, 0);
    chk("restart_data", oDATA, 12'h5A5);

`ifdef RAW_TEST_PATTERN_EN
    // Test pattern with an empty FIFO
    @(negedge iCLK); iRST = 1'b0; iSTART = 1'b0;
    fifoInf = 1'b0; cnt = 0; ptr = 0; forceEmpty = 1'b0; iPATTERN_SEL = 1'b1; drive();
    @(negedge iCLK); iRST = 1'b1;
    tick(1'b1, 1'b0);
    nPop = 0; nUf = 0; nHit = 0;
    for (int c = 0; c < 22; c++) begin
      tick(1'b0, 1'b0);
      if (pop) nPop++;
      if (oUNDERFLOW) nUf++;
      if (oDVAL && oX_Cont == 11'd3 && oY_Cont == 11'd1) begin
        nHit++;
        chk("pat_x3y1", oDATA, 12'h043);
      end
      if (oDVAL && oX_Cont == 11'd1 && oY_Cont == 11'd0) chk("pat_x1y0", oDATA, 12'h001);
    end
    chk("pat_rdreq_count", nPop, 0);
    chk("pat_uf_count", nUf, 0);
    chk("pat_hit_count", nHit, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
